// File: rtl/zircon_ip_len_cksum_ins_if.sv
// AXI-Stream bundle used throughout the Zircon TX path: src drives the beat,
// snk returns tready.
interface taxi_axis_if #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int ID_W   = 8,
    parameter int DEST_W = 8,
    parameter int USER_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, input tready);
    modport snk (input tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, output tready);
    modport master (output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, input tready);
    modport slave (input tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/zircon_ip_len_cksum_ins.sv
// Inserts IP length and header checksum fields into a streaming packet from held metadata.
// Optional macro ZIRCON_IP_LEN_CSUM_FIXUP_EN folds the written length into the checksum.
module zircon_ip_len_cksum_ins #(
    parameter int KEEP_W      = 8,
    parameter int LEN_OFFSET  = 16,
    parameter int CSUM_OFFSET = 24,
    parameter int LEN_SUB     = 14
) (
    input  logic     clk,
    input  logic     rst,
    taxi_axis_if.snk s_axis_pkt,
    taxi_axis_if.src m_axis_pkt,
    taxi_axis_if.snk s_axis_meta,
    output logic     stat_short
);
    localparam int DATA_W  = 8 * KEEP_W;
    localparam int MAX_OFF = (LEN_OFFSET > CSUM_OFFSET) ? LEN_OFFSET : CSUM_OFFSET;
    localparam int CNT_MAX = (MAX_OFF + 1) / KEEP_W + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic {WAIT_META = 1'b0, PKT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              len_wr_q, len_wr_d;
    logic              csum_wr_q, csum_wr_d;
    logic              stat_short_q, stat_short_d;
    logic [15:0]       len_field_q, len_field_d;
    logic [15:0]       csum_field_q, csum_field_d;

    logic              meta_valid;
    logic              pkt_xfer;
    logic              last_xfer;
    logic              meta_acc;
    logic              len_hit;
    logic              csum_hit;
    logic [DATA_W-1:0] pdata;
    logic              unused_meta;

    // Ones'-complement add with a single end-around carry; cannot overflow twice.
    function automatic logic [15:0] fold16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    assign meta_valid        = (state_q == PKT);
    assign s_axis_pkt.tready = m_axis_pkt.tready & meta_valid;
    assign pkt_xfer          = s_axis_pkt.tvalid & s_axis_pkt.tready;
    assign last_xfer         = pkt_xfer & s_axis_pkt.tlast;
    assign s_axis_meta.tready = ~meta_valid | last_xfer;
    assign meta_acc          = s_axis_meta.tvalid & s_axis_meta.tready;

    assign m_axis_pkt.tvalid = s_axis_pkt.tvalid & meta_valid;
    assign m_axis_pkt.tdata  = pdata;
    assign m_axis_pkt.tkeep  = s_axis_pkt.tkeep;
    assign m_axis_pkt.tstrb  = s_axis_pkt.tstrb;
    assign m_axis_pkt.tlast  = s_axis_pkt.tlast;
    assign m_axis_pkt.tid    = s_axis_pkt.tid;
    assign m_axis_pkt.tdest  = s_axis_pkt.tdest;
    assign m_axis_pkt.tuser  = s_axis_pkt.tuser;
    assign stat_short        = stat_short_q;

    assign unused_meta = ^{s_axis_meta.tkeep, s_axis_meta.tstrb, s_axis_meta.tlast,
                           s_axis_meta.tid, s_axis_meta.tdest, s_axis_meta.tuser};

    // Byte lanes count from the packet start regardless of tkeep.
    always_comb begin
        pdata    = s_axis_pkt.tdata;
        len_hit  = 1'b0;
        csum_hit = 1'b0;
        for (int j = 0; j < KEEP_W; j++) begin
            if (int'(beat_cnt_q) * KEEP_W + j == LEN_OFFSET)
                pdata[8*j +: 8] = len_field_q[15:8];
            if (int'(beat_cnt_q) * KEEP_W + j == LEN_OFFSET + 1) begin
                pdata[8*j +: 8] = len_field_q[7:0];
                len_hit = 1'b1;
            end
            if (int'(beat_cnt_q) * KEEP_W + j == CSUM_OFFSET)
                pdata[8*j +: 8] = csum_field_q[15:8];
            if (int'(beat_cnt_q) * KEEP_W + j == CSUM_OFFSET + 1) begin
                pdata[8*j +: 8] = csum_field_q[7:0];
                csum_hit = 1'b1;
            end
        end
    end

    always_comb begin
        len_field_d = s_axis_meta.tdata[15:0] - 16'(LEN_SUB);
`ifdef ZIRCON_IP_LEN_CSUM_FIXUP_EN
        // Upstream summed the header with a zero length field; add it back in.
        csum_field_d = ~fold16(s_axis_meta.tdata[31:16], len_field_d);
`else
        csum_field_d = ~s_axis_meta.tdata[31:16];
`endif
    end

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        len_wr_d     = len_wr_q;
        csum_wr_d    = csum_wr_q;
        stat_short_d = last_xfer & ~((len_wr_q | len_hit) & (csum_wr_q | csum_hit));
        if (meta_acc)
            state_d = PKT;
        else if (last_xfer)
            state_d = WAIT_META;
        if (last_xfer) begin
            beat_cnt_d = '0;
            len_wr_d   = 1'b0;
            csum_wr_d  = 1'b0;
        end else if (pkt_xfer) begin
            if (beat_cnt_q != CNT_W'(CNT_MAX))
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            len_wr_d  = len_wr_q | len_hit;
            csum_wr_d = csum_wr_q | csum_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_META;
            beat_cnt_q   <= '0;
            len_wr_q     <= 1'b0;
            csum_wr_q    <= 1'b0;
            stat_short_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            len_wr_q     <= len_wr_d;
            csum_wr_q    <= csum_wr_d;
            stat_short_q <= stat_short_d;
        end
    end

    always_ff @(posedge clk) begin
        if (meta_acc) begin
            len_field_q  <= len_field_d;
            csum_field_q <= csum_field_d;
        end
    end
endmodule

// File: tb/tb_zircon_ip_len_cksum_ins.sv
// Directed bench for zircon_ip_len_cksum_ins: an 8-byte-lane instance with default offsets
// and a 4-byte-lane instance with the length field straddling a beat boundary.
module tb_zircon_ip_len_cksum_ins;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic short8, short4;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    taxi_axis_if #(.DATA_W(64), .KEEP_W(8)) s8 ();
    taxi_axis_if #(.DATA_W(64), .KEEP_W(8)) m8 ();
    taxi_axis_if #(.DATA_W(32), .KEEP_W(4)) meta8 ();
    taxi_axis_if #(.DATA_W(32), .KEEP_W(4)) s4 ();
    taxi_axis_if #(.DATA_W(32), .KEEP_W(4)) m4 ();
    taxi_axis_if #(.DATA_W(32), .KEEP_W(4)) meta4 ();

    zircon_ip_len_cksum_ins #(.KEEP_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .s_axis_pkt(s8), .m_axis_pkt(m8),
        .s_axis_meta(meta8), .stat_short(short8));

    zircon_ip_len_cksum_ins #(.KEEP_W(4), .LEN_OFFSET(15)) u_dut4 (
        .clk(clk), .rst(rst), .s_axis_pkt(s4), .m_axis_pkt(m4),
        .s_axis_meta(meta4), .stat_short(short4));

    typedef struct {
        logic [15:0] len;
        logic [15:0] cs;
        logic [7:0]  e16, e17, e24, e25;
    } vec_t;
    vec_t vt[4];

    logic [63:0] q8d[$];
    bit          q8l[$];
    int          q8c[$];
    bit          q8mr[$];
    logic [31:0] q4d[$];
    int          short8_cnt = 0;
    int          short8_cyc = 0;
    int          pt_err8 = 0;

    always @(negedge clk) begin
        if (!rst && m8.tvalid && m8.tready) begin
            q8d.push_back(m8.tdata);
            q8l.push_back(m8.tlast);
            q8c.push_back(cyc);
            q8mr.push_back(meta8.tready);
            if (m8.tid !== 8'h3C || m8.tdest !== 8'hC3 || m8.tuser !== 1'b1 ||
                m8.tstrb !== s8.tstrb || m8.tkeep !== s8.tkeep || m8.tlast !== s8.tlast)
                pt_err8 <= pt_err8 + 1;
        end
        if (!rst && m4.tvalid && m4.tready)
            q4d.push_back(m4.tdata);
        if (short8) begin
            short8_cnt <= short8_cnt + 1;
            short8_cyc <= cyc;
        end
    end

    function automatic logic [7:0] pb(int p, int i);
        return 8'((i * 3 + p * 17 + 1) & 255);
    endfunction

    function automatic logic [7:0] ob8(int k);
        logic [63:0] w;
        w = q8d[k / 8];
        return w[8*(k % 8) +: 8];
    endfunction

    function automatic logic [7:0] ob4(int k);
        logic [31:0] w;
        w = q4d[k / 4];
        return w[8*(k % 4) +: 8];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input string nm, ref logic rdy);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) chk({nm, "_timeout"}, 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_meta8(input logic [15:0] len, input logic [15:0] cs);
        meta8.tdata  = {cs, len};
        meta8.tvalid = 1'b1;
        wait_rdy("meta8", meta8.tready);
        meta8.tvalid = 1'b0;
    endtask

    task automatic send_meta4(input logic [15:0] len, input logic [15:0] cs);
        meta4.tdata  = {cs, len};
        meta4.tvalid = 1'b1;
        wait_rdy("meta4", meta4.tready);
        meta4.tvalid = 1'b0;
    endtask

    task automatic beat8(input int p, input int b, input int nbytes);
        logic [63:0] d;
        logic [7:0]  k;
        for (int l = 0; l < 8; l++) begin
            d[8*l +: 8] = pb(p, b * 8 + l);
            k[l]        = (b * 8 + l < nbytes);
        end
        s8.tdata  = d;
        s8.tkeep  = k;
        s8.tstrb  = k;
        s8.tlast  = ((b + 1) * 8 >= nbytes);
        s8.tvalid = 1'b1;
        wait_rdy("pkt8", s8.tready);
    endtask

    // Leaves tvalid high after the last beat so packets can be chained; caller drops it.
    task automatic send_pkt8(input int p, input int nbytes);
        for (int b = 0; b < (nbytes + 7) / 8; b++) beat8(p, b, nbytes);
    endtask

    task automatic send_pkt4(input int p, input int nbytes);
        for (int b = 0; b < (nbytes + 3) / 4; b++) begin
            for (int l = 0; l < 4; l++) s4.tdata[8*l +: 8] = pb(p, b * 4 + l);
            s4.tkeep  = 4'hF;
            s4.tstrb  = 4'hF;
            s4.tlast  = ((b + 1) * 4 >= nbytes);
            s4.tvalid = 1'b1;
            wait_rdy("pkt4", s4.tready);
        end
        s4.tvalid = 1'b0;
    endtask

    task automatic clr;
        q8d.delete(); q8l.delete(); q8c.delete(); q8mr.delete(); q4d.delete();
    endtask

    task automatic chk_fields8(input string nm, input int base, input vec_t v);
        chk({nm, "_b16"}, ob8(base + 16), v.e16);
        chk({nm, "_b17"}, ob8(base + 17), v.e17);
        chk({nm, "_b24"}, ob8(base + 24), v.e24);
        chk({nm, "_b25"}, ob8(base + 25), v.e25);
    endtask

    task automatic chk_pass8(input string nm, input int base, input int p);
        int bad;
        bad = 0;
        for (int k = 0; k < 64; k++)
            if (k != 16 && k != 17 && k != 24 && k != 25 && ob8(base + k) !== pb(p, k)) bad++;
        chk({nm, "_passthru"}, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
`ifdef ZIRCON_IP_LEN_CSUM_FIXUP_EN
        vt[0] = '{16'h004A, 16'h1234, 8'h00, 8'h3C, 8'hED, 8'h8F};
        vt[1] = '{16'h0000, 16'hFFFF, 8'hFF, 8'hF2, 8'h00, 8'h0D};
        vt[2] = '{16'h05DC, 16'h8000, 8'h05, 8'hCE, 8'h7A, 8'h31};
        vt[3] = '{16'h000E, 16'h0001, 8'h00, 8'h00, 8'hFF, 8'hFE};
`else
        vt[0] = '{16'h004A, 16'h1234, 8'h00, 8'h3C, 8'hED, 8'hCB};
        vt[1] = '{16'h0000, 16'hFFFF, 8'hFF, 8'hF2, 8'h00, 8'h00};
        vt[2] = '{16'h05DC, 16'h8000, 8'h05, 8'hCE, 8'h7F, 8'hFF};
        vt[3] = '{16'h000E, 16'h0001, 8'h00, 8'h00, 8'hFF, 8'hFE};
`endif
        s8.tvalid = 1'b1; s8.tdata = '1; s8.tkeep = '1; s8.tstrb = '1; s8.tlast = 1'b0;
        s8.tid = 8'h3C; s8.tdest = 8'hC3; s8.tuser = 1'b1;
        meta8.tvalid = 1'b0; meta8.tdata = '0; meta8.tkeep = '1; meta8.tstrb = '1;
        meta8.tlast = 1'b0; meta8.tid = '0; meta8.tdest = '0; meta8.tuser = '0;
        s4.tvalid = 1'b0; s4.tdata = '0; s4.tkeep = '1; s4.tstrb = '1; s4.tlast = 1'b0;
        s4.tid = '0; s4.tdest = '0; s4.tuser = '0;
        meta4.tvalid = 1'b0; meta4.tdata = '0; meta4.tkeep = '1; meta4.tstrb = '1;
        meta4.tlast = 1'b0; meta4.tid = '0; meta4.tdest = '0; meta4.tuser = '0;
        m8.tready = 1'b1;
        m4.tready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_meta_tready", meta8.tready, 1);
        chk("rst_m_tvalid", m8.tvalid, 0);
        chk("rst_s_tready", s8.tready, 0);
        chk("rst_stat_short", short8, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Packet offered with no metadata held must stall.
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (m8.tvalid !== 1'b0 || s8.tready !== 1'b0) bad++;
        end
        chk("gating_no_meta", bad, 0);
        @(posedge clk); #1;
        s8.tvalid = 1'b0;

        for (int v = 0; v < 4; v++) begin
            clr();
            send_meta8(vt[v].len, vt[v].cs);
            send_pkt8(v, 64);
            s8.tvalid = 1'b0;
            idle(3);
            chk($sformatf("vec%0d_beats", v), q8d.size(), 8);
            chk_fields8($sformatf("vec%0d", v), 0, vt[v]);
            chk_pass8($sformatf("vec%0d", v), 0, v);
        end
        chk("full_pkts_no_short", short8_cnt, 0);

        clr();
        fork
            begin
                send_meta8(vt[2].len, vt[2].cs);
                send_meta8(vt[1].len, vt[1].cs);
            end
            begin
                send_pkt8(10, 64);
                send_pkt8(11, 64);
                s8.tvalid = 1'b0;
            end
        join
        idle(3);
        chk("b2b_beats", q8d.size(), 16);
        bad = 0;
        for (int i = 1; i < q8c.size(); i++) if (q8c[i] != q8c[i-1] + 1) bad++;
        chk("b2b_bubbles", bad, 0);
        chk("b2b_meta_rdy_on_tlast", {31'd0, q8l[7] & q8mr[7]}, 1);
        chk_fields8("b2b_p0", 0, vt[2]);
        chk_fields8("b2b_p1", 64, vt[1]);
        chk_pass8("b2b_p1", 64, 11);
        chk("b2b_no_short", short8_cnt, 0);

        clr();
        bad = short8_cnt;
        send_meta8(16'h004A, 16'h1234);
        send_pkt8(20, 20);
        s8.tvalid = 1'b0;
        idle(4);
        chk("short_beats", q8d.size(), 3);
        chk("short_b16", ob8(16), 8'h00);
        chk("short_b17", ob8(17), 8'h3C);
        chk("short_b18", ob8(18), pb(20, 18));
        bad = short8_cnt - bad;
        chk("short_pulses", bad, 1);
        chk("short_pulse_cycle", short8_cyc, q8c[2] + 1);
        bad = 0;
        for (int k = 20; k < 24; k++) if (ob8(k) !== pb(20, k)) bad++;
        chk("short_beyond_keep", bad, 0);

        clr();
        send_meta4(16'h0100, 16'h0000);
        send_pkt4(7, 32);
        idle(3);
        chk("straddle_beats", q4d.size(), 8);
        chk("straddle_b15", ob4(15), 8'h00);
        chk("straddle_b16", ob4(16), 8'hF2);
`ifdef ZIRCON_IP_LEN_CSUM_FIXUP_EN
        chk("straddle_b24", ob4(24), 8'hFF);
        chk("straddle_b25", ob4(25), 8'h0D);
`else
        chk("straddle_b24", ob4(24), 8'hFF);
        chk("straddle_b25", ob4(25), 8'hFF);
`endif
        bad = 0;
        for (int k = 0; k < 32; k++)
            if (k != 15 && k != 16 && k != 24 && k != 25 && ob4(k) !== pb(7, k)) bad++;
        chk("straddle_passthru", bad, 0);

        // Abandon a packet two beats in, then start over after reset.
        clr();
        send_meta8(16'h004A, 16'h1234);
        beat8(30, 0, 64);
        beat8(30, 1, 64);
        s8.tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        s8.tvalid = 1'b1;
        @(negedge clk);
        chk("midrst_meta_tready", meta8.tready, 1);
        chk("midrst_m_tvalid", m8.tvalid, 0);
        @(posedge clk); #1;
        s8.tvalid = 1'b0;
        clr();
        send_meta8(vt[2].len, vt[2].cs);
        send_pkt8(31, 64);
        s8.tvalid = 1'b0;
        idle(3);
        chk("midrst_beats", q8d.size(), 8);
        chk_fields8("midrst", 0, vt[2]);
        chk_pass8("midrst", 0, 31);
        chk("sideband_passthru", pt_err8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/zircon_ip_len_cksum_ins.md
# zircon_ip_len_cksum_ins

Writes the IP length and header checksum fields into a packet stream, using length/checksum metadata produced upstream by the Zircon length/checksum computation block. It sits in the Zircon TX path after the packet FIFO and ahead of the MAC. Each metadata word is held, then applied byte-accurately to the matching packet as it streams through, so no store-and-forward is needed here.

## Interface
- LEN_OFFSET, 16: byte offset from packet start of the big-endian 16-bit length field.
- CSUM_OFFSET, 24: byte offset of the big-endian 16-bit checksum field.
- LEN_SUB, 14: constant subtracted from the metadata length before writing the length field.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- s_axis_pkt  taxi_axis_if.snk  DATA_W  packet input; DATA_W = 8*KEEP_W, KEEP_W ≥ 2.
- m_axis_pkt  taxi_axis_if.src  DATA_W  patched packet output; tid/tdest/tuser/tstrb pass through.
- s_axis_meta  taxi_axis_if.snk  32  metadata; tdata[15:0] = length, tdata[31:16] = ones'-complement sum. tlast, tid, tdest and tuser are ignored.
- stat_short  out  1  one-cycle pulse: a packet ended before both fields were fully written.

## Operation
- Metadata holding register: meta_valid, len_field, csum_field.
- On metadata accept:
  - len_field = (len − LEN_SUB) mod 2^16.
  - csum_field is computed per Configuration.
  - meta_valid set.
- Packet gating:
  - m_axis_pkt.tvalid = s_axis_pkt.tvalid && meta_valid.
  - s_axis_pkt.tready = m_axis_pkt.tready && meta_valid.
  - A packet beat never transfers without held metadata.
- s_axis_meta.tready = !meta_valid || (last-beat transfer this cycle). This allows back-to-back packets with no bubble.
- Beat counter beat_cnt:
  - Zeroed on reset and on each tlast transfer.
  - Otherwise increments per transfer, saturating once beat_cnt*KEEP_W > max(LEN_OFFSET, CSUM_OFFSET)+1.
- Patching, per output byte j with absolute index a = beat_cnt*KEEP_W + j:
  - a==LEN_OFFSET → len_field[15:8]; a==LEN_OFFSET+1 → len_field[7:0].
  - a==CSUM_OFFSET → csum_field[15:8]; a==CSUM_OFFSET+1 → csum_field[7:0].
  - All other bytes pass unchanged.
  - Fields may straddle a beat boundary.
  - tkeep is not modified; a byte with tkeep=0 still counts toward a.
- Two written flags (one per field) set when the field's second byte transfers. If tlast transfers with either flag clear, pulse stat_short the next cycle. The packet is still forwarded unmodified beyond its end.
- meta_valid clears on tlast transfer unless new metadata is accepted in the same cycle. Simultaneous accept wins: the register loads the new values and meta_valid stays 1.
- States:
  - WAIT_META: meta_valid=0; goes to PKT on metadata accept.
  - PKT: goes to WAIT_META on tlast with no new metadata, or stays in PKT with new metadata.

## Timing
- Packet path is combinational: zero latency, data/keep muxed by byte-compare.
- Metadata to first beat eligible: 1 cycle (registered).
- stat_short: 1 cycle after the offending tlast transfer.
- Reset values:
  - meta_valid=0, beat_cnt=0, flags=0, stat_short=0.
  - Hence s_axis_meta.tready=1, m_axis_pkt.tvalid=0, s_axis_pkt.tready=0.
- Reset mid-packet discards the held metadata and counter. The next beat after reset is treated as byte 0 of a new packet once new metadata arrives.
- m_axis_pkt.tvalid depends on s_axis_pkt.tvalid; no registered slice here.

## Configuration
- ZIRCON_IP_LEN_CSUM_FIXUP_EN defined:
  - csum_field = ~fold16(csum + len_field), using end-around carry.
  - Compensates for the length field having been zero when the sum was computed upstream.
- Undefined: csum_field = ~csum.
- Fold step: 17-bit add, then add the carry back in; result is 16 bits.

## Test plan
- Byte patching, KEEP_W=8, defaults, no macro; meta len=0x004A, csum=0x1234, 64-byte packet:
  - Bytes 16,17 = 0x00,0x3C.
  - Bytes 24,25 = 0xED,0xCB.
  - All other bytes identical to input.
- Fixup, same stimulus with ZIRCON_IP_LEN_CSUM_FIXUP_EN: bytes 24,25 = 0xED,0x8F.
- Straddle, KEEP_W=4, LEN_OFFSET=15, meta len=0x0100: byte 15 of beat 3 = 0x00 and byte 0 of beat 4 = 0xF2.
- Back-to-back:
  - Two metadata words queued and two packets streamed with tready=1.
  - No idle cycle between packets; each packet carries its own fields.
  - meta tready high on the first packet's tlast cycle.
- Short packet: 20-byte packet, single tlast beat set → bytes 16,17 patched, stat_short pulses once, tdata beyond tkeep untouched.
- Gating/reset:
  - Packet valid without metadata → output tvalid=0 and s tready=0 for ≥10 cycles.
  - rst asserted mid-packet → meta tready=1 the next cycle and beat_cnt restarts at 0.
